// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and constants for the external-memory arbiter.
// Latency : n/a (definitions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, owner encodings and memory width codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    localparam logic OWNER_CART = 1'b0;
    localparam logic OWNER_USB  = 1'b1;

    localparam logic [1:0] WIDTH_8  = 2'b01;
    localparam logic [1:0] WIDTH_16 = 2'b10;
    localparam logic [1:0] WIDTH_32 = 2'b11;

endpackage

// File: rtl/mem_arb_prio.sv
// Purpose : cart/USB grant decision with a starvation guard for USB.
// Latency : grant is combinational from the request levels; streak updates on clk.
// Backpressure: grants only when arb_en is high; otherwise requests simply wait.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   arb_en        arbitration allowed this cycle
//   in_idle       arbiter FSM is in IDLE (used for streak clearing)
//   c_req, u_req  request levels from cart and USB
//   grant_cart    cart wins this cycle
//   grant_usb     USB wins this cycle
module mem_arb_prio #(
    parameter int MAX_CART_STREAK = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic in_idle,
    input  logic c_req,
    input  logic u_req,
    output logic grant_cart,
    output logic grant_usb
);

    localparam logic [7:0] MAX_S = 8'(MAX_CART_STREAK);

    // Number of consecutive cart grants made while USB was waiting.
    logic [7:0] streak;

    always_comb begin
        grant_cart = 1'b0;
        grant_usb  = 1'b0;
        if (arb_en) begin
            // Cart keeps priority until USB has been passed over MAX_S times.
            if (c_req && (!u_req || (streak < MAX_S))) begin
                grant_cart = 1'b1;
            end else if (u_req) begin
                grant_usb = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_usb) begin
            streak <= '0;
        end else if (in_idle && !u_req) begin
            // Nobody is starving, so the guard starts over.
            streak <= '0;
        end else if (grant_cart && u_req && (streak < MAX_S)) begin
            streak <= streak + 8'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : shares one external-memory port between the GBA cart path and the USB FIFO path.
// Latency : request sampled in IDLE at edge N -> mem strobe + ack at edge N+1 at the earliest.
// Backpressure: ISSUE holds until the matching mem ready; requesters hold their level until ack.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   c_rd/c_wr/c_addr/c_width/...    cart request side; c_ack, c_rd_data, c_rd_valid back
//   u_rd/u_wr/u_addr/u_wr_data      USB request side;  u_ack, u_rd_data, u_rd_valid back
//   mem_rd_ready/mem_wr_ready       memory accepts read / write
//   mem_rd_valid/mem_rd_data        read return from memory
//   mem_rd/mem_wr/mem_addr/...      registered one-cycle command strobes and payload
//   owner, busy, timeout_err        status (timeout_err is sticky until rst)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 26,
    parameter int DATA_W          = 32,
    parameter int MAX_CART_STREAK = 8,
    parameter int RD_TIMEOUT      = 1024
) (
    input  logic              clk,
    input  logic              rst,
    // cart side
    input  logic              c_rd,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [1:0]        c_width,
    input  logic [DATA_W-1:0] c_wr_data,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rd_data,
    output logic              c_rd_valid,
    // USB side
    input  logic              u_rd,
    input  logic              u_wr,
    input  logic [ADDR_W-1:0] u_addr,
    input  logic [DATA_W-1:0] u_wr_data,
    output logic              u_ack,
    output logic [DATA_W-1:0] u_rd_data,
    output logic              u_rd_valid,
    // memory side
    input  logic              mem_rd_ready,
    input  logic              mem_wr_ready,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_data_width,
    output logic [DATA_W-1:0] mem_wr_data,
    // status
    output logic              owner,
    output logic              busy,
    output logic              timeout_err
);

    localparam int          TW       = $clog2(RD_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic          op_rd;        // granted operation is a read
    logic [TW-1:0] tmo_cnt;

    logic arb_en;
    logic grant_cart;
    logic grant_usb;
    logic issue_fire;
    logic rd_done;
    logic rd_tmo;

    // No arbitration during the ack cycle: the requester only drops its level
    // after seeing ack, so the still-high request must not be granted twice.
    assign arb_en = (state == ST_IDLE) && !c_ack && !u_ack;
    assign busy   = (state != ST_IDLE);

    mem_arb_prio #(
        .MAX_CART_STREAK(MAX_CART_STREAK)
    ) u_prio (
        .clk        (clk),
        .rst        (rst),
        .arb_en     (arb_en),
        .in_idle    (state == ST_IDLE),
        .c_req      (c_rd | c_wr),
        .u_req      (u_rd | u_wr),
        .grant_cart (grant_cart),
        .grant_usb  (grant_usb)
    );

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue_fire = 1'b0;
        rd_done    = 1'b0;
        rd_tmo     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_cart || grant_usb) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // No timeout here: a stalled memory holds the command forever.
                if (op_rd ? mem_rd_ready : mem_wr_ready) begin
                    issue_fire = 1'b1;
                    state_next = op_rd ? ST_WAIT_RD : ST_IDLE;
                end
            end
            ST_WAIT_RD: begin
                // Valid data wins over a coincident timeout.
                if (mem_rd_valid) begin
                    rd_done    = 1'b1;
                    state_next = ST_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    rd_tmo     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath and registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_rd          <= 1'b0;
            owner          <= OWNER_CART;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_addr       <= '0;
            mem_data_width <= '0;
            mem_wr_data    <= '0;
            c_ack          <= 1'b0;
            u_ack          <= 1'b0;
            c_rd_data      <= '0;
            c_rd_valid     <= 1'b0;
            u_rd_data      <= '0;
            u_rd_valid     <= 1'b0;
            timeout_err    <= 1'b0;
            tmo_cnt        <= '0;
        end else begin
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            c_ack      <= 1'b0;
            u_ack      <= 1'b0;
            c_rd_valid <= 1'b0;
            u_rd_valid <= 1'b0;

            // Capture the winner's command; a requester with rd and wr both
            // high gets its read served first.
            if (grant_cart) begin
                owner          <= OWNER_CART;
                op_rd          <= c_rd;
                mem_addr       <= c_addr;
                mem_data_width <= c_width;
                mem_wr_data    <= c_wr_data;
            end else if (grant_usb) begin
                owner          <= OWNER_USB;
                op_rd          <= u_rd;
                mem_addr       <= u_addr;
                mem_data_width <= WIDTH_32;
                mem_wr_data    <= u_wr_data;
            end

            if (issue_fire) begin
                mem_rd  <= op_rd;
                mem_wr  <= !op_rd;
                tmo_cnt <= '0;
                if (owner == OWNER_USB) begin
                    u_ack <= 1'b1;
                end else begin
                    c_ack <= 1'b1;
                end
            end else if (state == ST_WAIT_RD) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            // Return path: real data, or all-ones when the read is abandoned.
            if (rd_done || rd_tmo) begin
                if (owner == OWNER_USB) begin
                    u_rd_data  <= rd_done ? mem_rd_data : '1;
                    u_rd_valid <= 1'b1;
                end else begin
                    c_rd_data  <= rd_done ? mem_rd_data : '1;
                    c_rd_valid <= 1'b1;
                end
            end

            if (rd_tmo) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : self-checking bench for mem_arbiter with a transaction scoreboard.
// Latency : n/a.
// Backpressure: exercised through mem_wr_ready stalls and a never-returning read.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_rd = 1'b0, c_wr = 1'b0;
    logic [25:0] c_addr = '0;
    logic [1:0]  c_width = '0;
    logic [31:0] c_wr_data = '0;
    logic        c_ack, c_rd_valid;
    logic [31:0] c_rd_data;
    logic        u_rd = 1'b0, u_wr = 1'b0;
    logic [25:0] u_addr = '0;
    logic [31:0] u_wr_data = '0;
    logic        u_ack, u_rd_valid;
    logic [31:0] u_rd_data;
    logic        mem_rd_ready = 1'b1, mem_wr_ready = 1'b1;
    logic        mem_rd_valid = 1'b0;
    logic [31:0] mem_rd_data = '0;
    logic        mem_rd, mem_wr;
    logic [25:0] mem_addr;
    logic [1:0]  mem_data_width;
    logic [31:0] mem_wr_data;
    logic        owner, busy, timeout_err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(26), .DATA_W(32), .MAX_CART_STREAK(8), .RD_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_width(c_width),
        .c_wr_data(c_wr_data), .c_ack(c_ack), .c_rd_data(c_rd_data), .c_rd_valid(c_rd_valid),
        .u_rd(u_rd), .u_wr(u_wr), .u_addr(u_addr), .u_wr_data(u_wr_data),
        .u_ack(u_ack), .u_rd_data(u_rd_data), .u_rd_valid(u_rd_valid),
        .mem_rd_ready(mem_rd_ready), .mem_wr_ready(mem_wr_ready),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_width(mem_data_width), .mem_wr_data(mem_wr_data),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        bit          usb;
        bit          rd;
        logic [25:0] addr;
        logic [31:0] data;
        logic [1:0]  w;
    } txn_t;

    typedef struct {
        bit          usb;
        logic [31:0] data;
    } ret_t;

    txn_t exp_q[$];
    ret_t ret_q[$];
    int   n_chk = 0;
    int   n_bad = 0;

    // Memory model controls.
    int          rd_lat = 1;       // cycles from mem_rd to mem_rd_valid; <0 means never
    logic [31:0] rd_val = '0;
    int          rd_cd = 0;
    bit          stale_req = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Memory responder, driven on the falling edge.
    always @(negedge clk) begin
        if (mem_rd && rd_lat >= 0) rd_cd = rd_lat;
        mem_rd_valid = 1'b0;
        if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = rd_val;
            end
        end
        if (stale_req) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'h1234_5678;
        end
    end

    // Output monitor: compares every strobe and every read return to the scoreboard.
    always @(posedge clk) begin
        txn_t t;
        ret_t r;
        #1;
        if (mem_rd || mem_wr) begin
            if (exp_q.size() == 0) begin
                chk("unexp_strobe", {62'd0, mem_rd, mem_wr}, 64'd0);
            end else begin
                t = exp_q.pop_front();
                chk("strobe_kind", {62'd0, mem_rd, mem_wr}, t.rd ? 64'd2 : 64'd1);
                chk("addr", 64'(mem_addr), 64'(t.addr));
                chk("width", 64'(mem_data_width), 64'(t.w));
                if (!t.rd) chk("wdata", 64'(mem_wr_data), 64'(t.data));
                chk("ack", {62'd0, c_ack, u_ack}, t.usb ? 64'd1 : 64'd2);
                chk("owner", 64'(owner), 64'(t.usb));
            end
        end else if (c_ack || u_ack) begin
            chk("ack_alone", {62'd0, c_ack, u_ack}, 64'd0);
        end
        if (c_rd_valid || u_rd_valid) begin
            if (ret_q.size() == 0) begin
                chk("unexp_rdv", {62'd0, c_rd_valid, u_rd_valid}, 64'd0);
            end else begin
                r = ret_q.pop_front();
                chk("rdv_side", {62'd0, c_rd_valid, u_rd_valid}, r.usb ? 64'd1 : 64'd2);
                chk("rdata", 64'(r.usb ? u_rd_data : c_rd_data), 64'(r.data));
            end
        end
    end

    // Raise a request, hold it until acked (twice when rd and wr are both set).
    task automatic do_req(input bit usb, input bit rd, input bit wr,
                          input logic [25:0] a, input logic [31:0] d, input logic [1:0] w,
                          input logic [31:0] rexp, input bit push, output int cyc);
        int need;
        int got;
        logic [1:0] ew;
        need = 32'(rd) + 32'(wr);
        got  = 0;
        cyc  = 0;
        ew   = usb ? 2'b11 : w;
        if (push) begin
            if (rd) begin
                exp_q.push_back('{usb: usb, rd: 1'b1, addr: a, data: d, w: ew});
                ret_q.push_back('{usb: usb, data: rexp});
            end
            if (wr) exp_q.push_back('{usb: usb, rd: 1'b0, addr: a, data: d, w: ew});
        end
        if (usb) begin
            u_rd = rd; u_wr = wr; u_addr = a; u_wr_data = d;
        end else begin
            c_rd = rd; c_wr = wr; c_addr = a; c_wr_data = d; c_width = w;
        end
        for (int k = 0; k < 400 && got < need; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (usb ? u_ack : c_ack) begin
                got++;
                if (usb) begin
                    if (u_rd) u_rd = 1'b0; else u_wr = 1'b0;
                end else begin
                    if (c_rd) c_rd = 1'b0; else c_wr = 1'b0;
                end
            end
        end
        if (got < need) begin
            chk("ack_wait", 64'(got), 64'(need));
            if (usb) begin u_rd = 1'b0; u_wr = 1'b0; end
            else begin c_rd = 1'b0; c_wr = 1'b0; end
        end
    endtask

    task automatic wait_quiet();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (!busy && exp_q.size() == 0 && ret_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("quiet_wait", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int cnt;
        int bcnt;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {54'd0, c_ack, u_ack, c_rd_valid, u_rd_valid, mem_rd, mem_wr,
                        owner, busy, timeout_err, mem_data_width == 2'b00}, 64'd1);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wr_data), 64'd0);
        chk("rst_rdata", {c_rd_data, u_rd_data}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ---- cart write ----
        do_req(0, 0, 1, 26'h10, 32'h0123_ABCD, 2'b10, '0, 1, cyc);
        chk("wr_lat", 64'(cyc), 64'd2);
        wait_quiet();

        // ---- cart read, 5-cycle latency ----
        rd_lat = 5; rd_val = 32'hDEAD_BEEF;
        do_req(0, 1, 0, 26'h20, '0, 2'b01, 32'hDEAD_BEEF, 1, cyc);
        wait_quiet();
        chk("u_rd_hold", 64'(u_rd_data), 64'd0);

        // ---- USB read ----
        rd_lat = 2; rd_val = 32'h5A5A_1234;
        do_req(1, 1, 0, 26'h55, '0, 2'b00, 32'h5A5A_1234, 1, cyc);
        wait_quiet();
        chk("c_rd_hold", 64'(c_rd_data), 64'hDEAD_BEEF);

        // ---- both requesting: 8 cart, 1 USB, repeating ----
        for (int i = 0; i < 18; i++) begin
            if (i == 8 || i == 17)
                exp_q.push_back('{usb: 1'b1, rd: 1'b0, addr: 26'h200 + 26'(i / 9),
                                  data: 32'hA000_0000 + 32'(i / 9), w: 2'b11});
            else
                exp_q.push_back('{usb: 1'b0, rd: 1'b0, addr: 26'h100 + 26'(i - (i / 9)),
                                  data: 32'hC000_0000 + 32'(i - (i / 9)), w: 2'b10});
        end
        fork
            begin
                int cc;
                for (int i = 0; i < 16; i++)
                    do_req(0, 0, 1, 26'h100 + 26'(i), 32'hC000_0000 + 32'(i), 2'b10, '0, 0, cc);
            end
            begin
                int cu;
                for (int j = 0; j < 2; j++)
                    do_req(1, 0, 1, 26'h200 + 26'(j), 32'hA000_0000 + 32'(j), 2'b00, '0, 0, cu);
            end
        join
        wait_quiet();

        // ---- write ready stalled for 20 cycles ----
        mem_wr_ready = 1'b0;
        cnt = 0;
        bcnt = 0;
        fork
            do_req(0, 0, 1, 26'h3F, 32'hCAFE_F00D, 2'b01, '0, 1, cyc);
            begin
                repeat (20) begin
                    @(posedge clk);
                    #1;
                    if (mem_wr) cnt++;
                    if (busy) bcnt++;
                end
                chk("stall_strobe", 64'(cnt), 64'd0);
                chk("stall_busy", 64'(bcnt), 64'd20);
                mem_wr_ready = 1'b1;
            end
        join
        wait_quiet();

        // ---- rd and wr together: read first, write needs its own ack ----
        rd_lat = 1; rd_val = 32'h0BAD_CAFE;
        do_req(0, 1, 1, 26'h77, 32'h1111_2222, 2'b10, 32'h0BAD_CAFE, 1, cyc);
        wait_quiet();

        // ---- read timeout ----
        rd_lat = -1;
        do_req(0, 1, 0, 26'h30, '0, 2'b10, 32'hFFFF_FFFF, 1, cyc);
        cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (c_rd_valid) begin
                cnt = k;
                break;
            end
        end
        chk("tmo_lat", 64'(cnt), 64'd16);
        chk("tmo_err", 64'(timeout_err), 64'd1);
        do_req(0, 0, 1, 26'h31, 32'h0000_0031, 2'b10, '0, 1, cyc);
        wait_quiet();
        chk("tmo_sticky", 64'(timeout_err), 64'd1);

        // ---- reset in WAIT_RD, then a stale valid ----
        do_req(0, 1, 0, 26'h40, '0, 2'b10, '0, 1, cyc);
        repeat (3) @(posedge clk);
        #1;
        chk("wait_busy", 64'(busy), 64'd1);
        ret_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst2_ctl", {55'd0, c_ack, u_ack, c_rd_valid, u_rd_valid, mem_rd, mem_wr,
                         owner, busy, timeout_err}, 64'd0);
        chk("rst2_rdata", {c_rd_data, u_rd_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        stale_req = 1'b1;
        @(posedge clk);
        #1;
        stale_req = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (c_rd_valid || u_rd_valid || busy) cnt++;
        end
        chk("stale_ignored", 64'(cnt), 64'd0);
        chk("stale_rdata", 64'(c_rd_data), 64'd0);
        do_req(0, 0, 1, 26'h50, 32'h5050_5050, 2'b01, '0, 1, cyc);
        chk("post_rst_lat", 64'(cyc), 64'd2);
        wait_quiet();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
